// File: rtl/ysyx_22050710_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_sram_arbiter_if
//   Bundle of the three SRAM-like channels seen by the arbiter:
//   inst master (read only), data master (read/write) and the shared memory
//   port. Signal names keep the i_/o_ prefixes as seen from the arbiter.
//
//   modport slave  : the arbiter side (takes i_*, drives o_*)
//   modport master : the environment side (core masters + memory bridge)
// ---------------------------------------------------------------------------
interface ysyx_22050710_sram_arbiter_if #(
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_DATA_WD  = 64,
  parameter int SRAM_WMASK_WD = 8
);
  // inst-sram channel
  logic                     i_inst_ren;
  logic [SRAM_ADDR_WD-1:0]  i_inst_addr;
  logic                     o_inst_addr_ok;
  logic                     o_inst_data_ok;
  logic [SRAM_DATA_WD-1:0]  o_inst_rdata;
  // data-sram channel
  logic                     i_data_ren;
  logic                     i_data_wen;
  logic [SRAM_ADDR_WD-1:0]  i_data_addr;
  logic [SRAM_WMASK_WD-1:0] i_data_wmask;
  logic [SRAM_DATA_WD-1:0]  i_data_wdata;
  logic                     o_data_addr_ok;
  logic                     o_data_data_ok;
  logic [SRAM_DATA_WD-1:0]  o_data_rdata;
  // shared memory channel
  logic                     o_mem_ren;
  logic                     o_mem_wen;
  logic [SRAM_ADDR_WD-1:0]  o_mem_addr;
  logic [SRAM_WMASK_WD-1:0] o_mem_wmask;
  logic [SRAM_DATA_WD-1:0]  o_mem_wdata;
  logic [SRAM_DATA_WD-1:0]  i_mem_rdata;
  logic                     i_mem_addr_ok;
  logic                     i_mem_data_ok;

  modport slave (
    input  i_inst_ren, i_inst_addr,
    output o_inst_addr_ok, o_inst_data_ok, o_inst_rdata,
    input  i_data_ren, i_data_wen, i_data_addr, i_data_wmask, i_data_wdata,
    output o_data_addr_ok, o_data_data_ok, o_data_rdata,
    output o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wmask, o_mem_wdata,
    input  i_mem_rdata, i_mem_addr_ok, i_mem_data_ok
  );

  modport master (
    output i_inst_ren, i_inst_addr,
    input  o_inst_addr_ok, o_inst_data_ok, o_inst_rdata,
    output i_data_ren, i_data_wen, i_data_addr, i_data_wmask, i_data_wdata,
    input  o_data_addr_ok, o_data_data_ok, o_data_rdata,
    input  o_mem_ren, o_mem_wen, o_mem_addr, o_mem_wmask, o_mem_wdata,
    output i_mem_rdata, i_mem_addr_ok, i_mem_data_ok
  );
endinterface

// File: rtl/ysyx_22050710_sram_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_sram_arbiter
//   Shares one SRAM-like memory port between the inst-sram master (IF, read
//   only) and the data-sram master (EX/MEM, read/write). All channels use the
//   addr_ok/data_ok split handshake.
//
//   Ports:
//     i_clk  - clock
//     i_rst  - asynchronous active-high reset; all outputs read 0 while high
//     bus    - ysyx_22050710_sram_arbiter_if.slave: inst, data and memory
//              channels (request/payload pass-through of the winner, addr_ok
//              steering, in-order data_ok steering via a requester-ID FIFO)
//
//   Arbitration:
//     Default build: fixed priority, data beats inst (data request belongs
//     to an older instruction).
//     `define YSYX_22050710_SRAM_ARB_RR_EN: round-robin using a 1-bit
//     favour-data register, reset to favour data.
//     In both builds a request driven without i_mem_addr_ok locks the grant
//     to that master until it is accepted.
//
//   Up to MAX_OUTSTANDING (power of two, 1..8) accepted transactions may be
//   awaiting response; at the limit no request is presented to memory.
// ---------------------------------------------------------------------------
module ysyx_22050710_sram_arbiter #(
  parameter int SRAM_ADDR_WD    = 32,
  parameter int SRAM_DATA_WD    = 64,
  parameter int SRAM_WMASK_WD   = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  ysyx_22050710_sram_arbiter_if.slave bus
);

  localparam int CNT_WD = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WD = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  // Pointer increment with explicit wrap so MAX_OUTSTANDING == 1 stays at 0.
  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] ptr);
    logic [PTR_WD-1:0] nxt;
    if (ptr == PTR_WD'(MAX_OUTSTANDING - 1)) begin
      nxt = {PTR_WD{1'b0}};
    end else begin
      nxt = ptr + PTR_WD'(1);
    end
    return nxt;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_WD-1:0]          cnt_r;
  logic [PTR_WD-1:0]          wr_ptr_r;
  logic [PTR_WD-1:0]          rd_ptr_r;
  logic [MAX_OUTSTANDING-1:0] id_fifo_r;
  logic                       lock_r;
  logic                       lock_id_r;
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  logic                       favour_data_r;
`endif

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic inst_req_s;
  logic data_req_s;
  logic grant_data_s;
  logic win_req_s;
  logic full_s;
  logic drive_s;
  logic accept_s;
  logic pop_s;
  logic head_id_s;

  assign inst_req_s = bus.i_inst_ren;
  assign data_req_s = bus.i_data_ren | bus.i_data_wen;

  // At the limit the request is masked from cnt alone; i_mem_data_ok never
  // reaches the request path, so a same-cycle response cannot free a slot.
  assign full_s = (cnt_r == CNT_WD'(MAX_OUTSTANDING));

  // Grant selection: a pending (driven, not yet accepted) request keeps the
  // port; otherwise the priority scheme decides.
  always_comb begin
    grant_data_s = ID_INST;
    if (lock_r) begin
      grant_data_s = lock_id_r;
    end else begin
`ifdef YSYX_22050710_SRAM_ARB_RR_EN
      if (inst_req_s && data_req_s) begin
        grant_data_s = favour_data_r;
      end else begin
        grant_data_s = data_req_s;
      end
`else
      grant_data_s = data_req_s;
`endif
    end
  end

  assign win_req_s = grant_data_s ? data_req_s : inst_req_s;
  assign drive_s   = win_req_s & ~full_s & ~i_rst;
  assign accept_s  = drive_s & bus.i_mem_addr_ok;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign pop_s     = bus.i_mem_data_ok & (cnt_r != {CNT_WD{1'b0}}) & ~i_rst;
  assign head_id_s = id_fifo_r[rd_ptr_r];

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.o_mem_ren   = drive_s & (grant_data_s ? bus.i_data_ren : 1'b1);
  assign bus.o_mem_wen   = drive_s & grant_data_s & bus.i_data_wen;
  assign bus.o_mem_addr  = i_rst ? {SRAM_ADDR_WD{1'b0}}
                         : (grant_data_s ? bus.i_data_addr : bus.i_inst_addr);
  assign bus.o_mem_wmask = bus.o_mem_wen ? bus.i_data_wmask : {SRAM_WMASK_WD{1'b0}};
  assign bus.o_mem_wdata = (drive_s & grant_data_s) ? bus.i_data_wdata
                                                    : {SRAM_DATA_WD{1'b0}};

  assign bus.o_inst_addr_ok = accept_s & (grant_data_s == ID_INST);
  assign bus.o_data_addr_ok = accept_s & (grant_data_s == ID_DATA);

  assign bus.o_inst_data_ok = pop_s & (head_id_s == ID_INST);
  assign bus.o_data_data_ok = pop_s & (head_id_s == ID_DATA);

  assign bus.o_inst_rdata = i_rst ? {SRAM_DATA_WD{1'b0}} : bus.i_mem_rdata;
  assign bus.o_data_rdata = i_rst ? {SRAM_DATA_WD{1'b0}} : bus.i_mem_rdata;

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------

  // Outstanding counter: push and pop in the same cycle cancel out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= {CNT_WD{1'b0}};
    end else begin
      case ({accept_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_WD'(1);
        2'b01:   cnt_r <= cnt_r - CNT_WD'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // ID FIFO: push winner on accept, pop head on response. The pop reads the
  // old head, so it can never see the entry pushed in the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_r  <= {PTR_WD{1'b0}};
      rd_ptr_r  <= {PTR_WD{1'b0}};
      id_fifo_r <= {MAX_OUTSTANDING{1'b0}};
    end else begin
      if (accept_s) begin
        id_fifo_r[wr_ptr_r] <= grant_data_s;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Grant lock: set while the winner is driven without acceptance, cleared
  // once it is accepted (or if the request goes away).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_r    <= 1'b0;
      lock_id_r <= ID_INST;
    end else begin
      lock_r <= drive_s & ~bus.i_mem_addr_ok;
      if (drive_s) begin
        lock_id_r <= grant_data_s;
      end
    end
  end

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
  // Round-robin: after each accept, favour the master that did not win.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      favour_data_r <= 1'b1;
    end else if (accept_s) begin
      favour_data_r <= ~grant_data_s;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed self-checking bench for ysyx_22050710_sram_arbiter.
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 unit later, well clear of the next rising edge.
module tb_ysyx_22050710_sram_arbiter;

  logic clk;
  logic rst;
  int   check_count;
  int   error_count;

  ysyx_22050710_sram_arbiter_if #(
    .SRAM_ADDR_WD (32),
    .SRAM_DATA_WD (64),
    .SRAM_WMASK_WD(8)
  ) bus ();

  ysyx_22050710_sram_arbiter #(
    .SRAM_ADDR_WD   (32),
    .SRAM_DATA_WD   (64),
    .SRAM_WMASK_WD  (8),
    .MAX_OUTSTANDING(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_inst_ren    = 1'b0;
    bus.i_inst_addr   = 32'h0;
    bus.i_data_ren    = 1'b0;
    bus.i_data_wen    = 1'b0;
    bus.i_data_addr   = 32'h0;
    bus.i_data_wmask  = 8'h0;
    bus.i_data_wdata  = 64'h0;
    bus.i_mem_rdata   = 64'h0;
    bus.i_mem_addr_ok = 1'b0;
    bus.i_mem_data_ok = 1'b0;
  endtask

  // Drive an inst read with immediate memory accept.
  task automatic inst_req(input logic [31:0] addr);
    bus.i_inst_ren    = 1'b1;
    bus.i_inst_addr   = addr;
    bus.i_mem_addr_ok = 1'b1;
  endtask

  // Drive one memory response with no new request.
  task automatic mem_resp(input logic [63:0] rdata);
    bus.i_inst_ren    = 1'b0;
    bus.i_data_ren    = 1'b0;
    bus.i_data_wen    = 1'b0;
    bus.i_mem_addr_ok = 1'b0;
    bus.i_mem_data_ok = 1'b1;
    bus.i_mem_rdata   = rdata;
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    idle_inputs();
    rst = 1'b1;

    // ---- reset: outputs held at 0 even with active inputs ----
    #2;
    bus.i_inst_ren    = 1'b1;
    bus.i_inst_addr   = 32'h8000_0000;
    bus.i_mem_addr_ok = 1'b1;
    bus.i_mem_data_ok = 1'b1;
    bus.i_mem_rdata   = 64'hdead_beef_0000_0001;
    settle();
    check_value("rst_mem_ren",      bus.o_mem_ren,      1'b0);
    check_value("rst_inst_addr_ok", bus.o_inst_addr_ok, 1'b0);
    check_value("rst_inst_data_ok", bus.o_inst_data_ok, 1'b0);
    check_value("rst_inst_rdata",   bus.o_inst_rdata,   64'h0);
    check_value("rst_mem_addr",     bus.o_mem_addr,     32'h0);
    tick();
    tick();
    idle_inputs();
    rst = 1'b0;

    // ---- T1: single inst read ----
    tick();
    inst_req(32'h8000_0000);
    settle();
    check_value("t1_mem_ren",       bus.o_mem_ren,      1'b1);
    check_value("t1_mem_addr",      bus.o_mem_addr,     32'h8000_0000);
    check_value("t1_mem_wmask",     bus.o_mem_wmask,    8'h00);
    check_value("t1_inst_addr_ok",  bus.o_inst_addr_ok, 1'b1);
    check_value("t1_data_addr_ok",  bus.o_data_addr_ok, 1'b0);
    tick();
    mem_resp(64'h1122_3344_5566_7788);
    settle();
    check_value("t1_inst_data_ok",  bus.o_inst_data_ok, 1'b1);
    check_value("t1_inst_rdata",    bus.o_inst_rdata,   64'h1122_3344_5566_7788);
    check_value("t1_data_data_ok",  bus.o_data_data_ok, 1'b0);
    check_value("t1_inst_addr_ok2", bus.o_inst_addr_ok, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_value("t1_inst_data_ok_end", bus.o_inst_data_ok, 1'b0);

    // ---- T2: inst read and data write together, data first ----
    tick();
    bus.i_inst_ren    = 1'b1;
    bus.i_inst_addr   = 32'h8000_0004;
    bus.i_data_wen    = 1'b1;
    bus.i_data_addr   = 32'h8000_1000;
    bus.i_data_wmask  = 8'h0F;
    bus.i_data_wdata  = 64'h0123_4567_89ab_cdef;
    bus.i_mem_addr_ok = 1'b1;
    settle();
    check_value("t2_mem_wen",       bus.o_mem_wen,      1'b1);
    check_value("t2_mem_ren",       bus.o_mem_ren,      1'b0);
    check_value("t2_mem_addr",      bus.o_mem_addr,     32'h8000_1000);
    check_value("t2_mem_wmask",     bus.o_mem_wmask,    8'h0F);
    check_value("t2_mem_wdata",     bus.o_mem_wdata,    64'h0123_4567_89ab_cdef);
    check_value("t2_data_addr_ok",  bus.o_data_addr_ok, 1'b1);
    check_value("t2_inst_addr_ok",  bus.o_inst_addr_ok, 1'b0);
    tick();
    bus.i_data_wen   = 1'b0;
    bus.i_data_wmask = 8'h00;
    settle();
    check_value("t2_inst_mem_ren",  bus.o_mem_ren,      1'b1);
    check_value("t2_inst_mem_addr", bus.o_mem_addr,     32'h8000_0004);
    check_value("t2_inst_wmask",    bus.o_mem_wmask,    8'h00);
    check_value("t2_inst_addr_ok",  bus.o_inst_addr_ok, 1'b1);
    tick();
    mem_resp(64'h0);
    settle();
    check_value("t2_resp1_data_ok", bus.o_data_data_ok, 1'b1);
    check_value("t2_resp1_inst_ok", bus.o_inst_data_ok, 1'b0);
    tick();
    mem_resp(64'haaaa_bbbb_cccc_dddd);
    settle();
    check_value("t2_resp2_inst_ok", bus.o_inst_data_ok, 1'b1);
    check_value("t2_resp2_data_ok", bus.o_data_data_ok, 1'b0);
    check_value("t2_resp2_rdata",   bus.o_inst_rdata,   64'haaaa_bbbb_cccc_dddd);
    tick();
    idle_inputs();

    // ---- T3: grant lock holds inst until accepted ----
    tick();
    bus.i_inst_ren  = 1'b1;
    bus.i_inst_addr = 32'h8000_0008;
    settle();
    check_value("t3_c1_addr",       bus.o_mem_addr,     32'h8000_0008);
    check_value("t3_c1_addr_ok",    bus.o_inst_addr_ok, 1'b0);
    tick();
    bus.i_data_ren  = 1'b1;
    bus.i_data_addr = 32'h8000_2000;
    settle();
    check_value("t3_c2_addr",       bus.o_mem_addr,     32'h8000_0008);
    check_value("t3_c2_data_ok",    bus.o_data_addr_ok, 1'b0);
    tick();
    settle();
    check_value("t3_c3_addr",       bus.o_mem_addr,     32'h8000_0008);
    tick();
    bus.i_mem_addr_ok = 1'b1;
    settle();
    check_value("t3_c4_addr",       bus.o_mem_addr,     32'h8000_0008);
    check_value("t3_c4_inst_ok",    bus.o_inst_addr_ok, 1'b1);
    check_value("t3_c4_data_ok",    bus.o_data_addr_ok, 1'b0);
    tick();
    bus.i_inst_ren = 1'b0;
    settle();
    check_value("t3_c5_addr",       bus.o_mem_addr,     32'h8000_2000);
    check_value("t3_c5_data_ok",    bus.o_data_addr_ok, 1'b1);
    check_value("t3_c5_mem_ren",    bus.o_mem_ren,      1'b1);
    tick();
    mem_resp(64'h1);
    settle();
    check_value("t3_resp1_inst",    bus.o_inst_data_ok, 1'b1);
    tick();
    mem_resp(64'h2);
    settle();
    check_value("t3_resp2_data",    bus.o_data_data_ok, 1'b1);
    check_value("t3_resp2_rdata",   bus.o_data_rdata,   64'h2);
    tick();
    idle_inputs();

    // ---- T4: outstanding limit of 2 ----
    tick();
    inst_req(32'h8000_0010);
    settle();
    check_value("t4_a1",            bus.o_inst_addr_ok, 1'b1);
    tick();
    bus.i_inst_addr = 32'h8000_0014;
    settle();
    check_value("t4_a2",            bus.o_inst_addr_ok, 1'b1);
    tick();
    bus.i_inst_addr = 32'h8000_0018;
    settle();
    check_value("t4_full_addr_ok",  bus.o_inst_addr_ok, 1'b0);
    check_value("t4_full_mem_ren",  bus.o_mem_ren,      1'b0);
    tick();
    bus.i_mem_data_ok = 1'b1;
    bus.i_mem_rdata   = 64'h10;
    settle();
    check_value("t4_full_with_resp", bus.o_inst_addr_ok, 1'b0);
    check_value("t4_resp_inst_ok",   bus.o_inst_data_ok, 1'b1);
    tick();
    bus.i_mem_data_ok = 1'b0;
    settle();
    check_value("t4_a3",            bus.o_inst_addr_ok, 1'b1);
    check_value("t4_a3_addr",       bus.o_mem_addr,     32'h8000_0018);
    tick();
    mem_resp(64'h14);
    settle();
    check_value("t4_drain1",        bus.o_inst_data_ok, 1'b1);
    tick();
    mem_resp(64'h18);
    settle();
    check_value("t4_drain2",        bus.o_inst_data_ok, 1'b1);
    tick();
    idle_inputs();

    // ---- T5: response with nothing outstanding, then reset mid-flight ----
    tick();
    mem_resp(64'h55);
    settle();
    check_value("t5_stray_inst",    bus.o_inst_data_ok, 1'b0);
    check_value("t5_stray_data",    bus.o_data_data_ok, 1'b0);
    tick();
    idle_inputs();
    inst_req(32'h8000_0020);
    settle();
    check_value("t5_pre_a1",        bus.o_inst_addr_ok, 1'b1);
    tick();
    bus.i_inst_addr = 32'h8000_0024;
    settle();
    check_value("t5_pre_a2",        bus.o_inst_addr_ok, 1'b1);
    tick();
    idle_inputs();
    rst = 1'b1;
    settle();
    check_value("t5_rst_mem_ren",   bus.o_mem_ren,      1'b0);
    tick();
    rst = 1'b0;
    tick();
    mem_resp(64'h66);
    settle();
    check_value("t5_late_inst",     bus.o_inst_data_ok, 1'b0);
    check_value("t5_late_data",     bus.o_data_data_ok, 1'b0);
    tick();
    idle_inputs();
    inst_req(32'h8000_0030);
    settle();
    check_value("t5_post_a1",       bus.o_inst_addr_ok, 1'b1);
    tick();
    bus.i_inst_addr = 32'h8000_0034;
    settle();
    check_value("t5_post_a2",       bus.o_inst_addr_ok, 1'b1);
    tick();
    bus.i_inst_addr = 32'h8000_0038;
    settle();
    check_value("t5_post_full",     bus.o_inst_addr_ok, 1'b0);
    tick();
    mem_resp(64'h30);
    settle();
    check_value("t5_post_resp",     bus.o_inst_data_ok, 1'b1);
    tick();
    mem_resp(64'h34);
    tick();
    idle_inputs();

`ifdef YSYX_22050710_SRAM_ARB_RR_EN
    // ---- T6: round-robin alternation ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.i_inst_ren    = 1'b1;
    bus.i_inst_addr   = 32'h8000_0040;
    bus.i_data_ren    = 1'b1;
    bus.i_data_addr   = 32'h8000_3000;
    bus.i_mem_addr_ok = 1'b1;
    settle();
    check_value("t6_g1_data",       bus.o_data_addr_ok, 1'b1);
    tick();
    bus.i_mem_data_ok = 1'b1;
    settle();
    check_value("t6_g2_inst",       bus.o_inst_addr_ok, 1'b1);
    tick();
    settle();
    check_value("t6_g3_data",       bus.o_data_addr_ok, 1'b1);
    tick();
    settle();
    check_value("t6_g4_inst",       bus.o_inst_addr_ok, 1'b1);
    tick();
    idle_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_sram_arbiter.md
Name: ysyx_22050710_sram_arbiter

Overview:
Shares one SRAM-like memory port between the core's inst-sram master (IF stage, read-only) and data-sram master (EX/MEM stages, read/write). Both sides use the addr_ok/data_ok split handshake. Arbitration is fixed-priority by default; round-robin is optional. Multiple transactions may be outstanding, and responses are routed in order through an internal requester-ID FIFO. The block sits between the core and the memory/bus bridge.

Parameters:
SRAM_ADDR_WD, 32, address width on all ports
SRAM_DATA_WD, 64, read/write data width
SRAM_WMASK_WD, 8, byte write mask width
MAX_OUTSTANDING, 2, depth of the ID FIFO; power of two, 1..8

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_inst_ren  in  1  inst read request
i_inst_addr  in  SRAM_ADDR_WD  inst address
o_inst_addr_ok  out  1  inst request accepted this cycle
o_inst_data_ok  out  1  inst read data valid
o_inst_rdata  out  SRAM_DATA_WD  inst read data
i_data_ren  in  1  data read request
i_data_wen  in  1  data write request; never asserted together with i_data_ren
i_data_addr  in  SRAM_ADDR_WD  data address
i_data_wmask  in  SRAM_WMASK_WD  write byte mask
i_data_wdata  in  SRAM_DATA_WD  write data
o_data_addr_ok  out  1  data request accepted this cycle
o_data_data_ok  out  1  data response (read data, or write ack)
o_data_rdata  out  SRAM_DATA_WD  data read data
o_mem_ren  out  1  memory read request
o_mem_wen  out  1  memory write request
o_mem_addr  out  SRAM_ADDR_WD  memory address
o_mem_wmask  out  SRAM_WMASK_WD  memory write mask; 0 for reads
o_mem_wdata  out  SRAM_DATA_WD  memory write data
i_mem_rdata  in  SRAM_DATA_WD  memory read data
i_mem_addr_ok  in  1  memory accepted request
i_mem_data_ok  in  1  memory response valid

Behaviour:
- Request handshake: a transfer is accepted on a cycle where the request (ren|wen) is high and addr_ok is high. Masters hold request and payload stable until accepted.
- Requests and addr_ok are combinational pass-throughs of the granted master. o_mem_* mirror the winner's request and payload. i_mem_addr_ok is routed only to the winner's addr_ok; the loser's addr_ok is 0.
- Default priority: data side wins over inst side, because the data request comes from an older instruction.
- Grant lock: once a master's request is driven to memory without i_mem_addr_ok, the grant is held to that master until acceptance. This lock register is set on drive-without-accept and cleared on accept.
- Outstanding limit: a counter cnt of width clog2(MAX_OUTSTANDING+1) tracks accepted-but-unanswered transactions.
  - When cnt == MAX_OUTSTANDING, o_mem_ren, o_mem_wen and both addr_ok outputs are forced to 0.
  - This holds even if i_mem_data_ok is high the same cycle. There is no combinational path from data_ok to the request.
- ID FIFO: on each accept, the winner's ID is pushed (0 = inst, 1 = data). On i_mem_data_ok, the head is popped.
  - Pop steers a 1-cycle data_ok pulse plus i_mem_rdata to the head's master. The other master's data_ok is 0.
  - rdata outputs pass i_mem_rdata through combinationally. They are valid only while the corresponding data_ok is high.
- Simultaneous accept and response in one cycle: push and pop both occur, and cnt is unchanged. A response can never pop the ID pushed in that same cycle.
- Pointers wrap modulo MAX_OUTSTANDING.
- i_mem_data_ok with cnt == 0 is a protocol error: ignored, no data_ok pulse, and cnt stays 0 (no underflow).
- Reset (asynchronous, any time) clears cnt, pointers, the grant lock and the RR pointer. While i_rst is high, every output is 0. Transactions outstanding at reset are discarded; late responses then hit the cnt == 0 rule.

Optional Feature:
- Macro YSYX_22050710_SRAM_ARB_RR_EN.
- Defined: round-robin priority. A 1-bit last-granted register flips to favour the other master after each accepted request. The grant lock still overrides it. The register resets to favour data.
- Undefined: fixed data-over-inst priority, and the last-granted register is absent.

Test Plan:
- Inst read only, addr 0x8000_0000, memory accepts immediately and answers next cycle with 0x1122_3344_5566_7788 -> o_inst_addr_ok for 1 cycle, o_inst_data_ok for 1 cycle with that rdata, o_data_data_ok stays 0.
- Inst read and data write (addr 0x8000_1000, wmask 0x0F) raised together -> data granted first with o_mem_wen=1 and wmask 0x0F; inst granted the next cycle; responses returned in order: data ack, then inst data.
- Grant lock: inst requesting, i_mem_addr_ok held 0 for 3 cycles, data request raised in cycle 2 -> o_mem_addr stays the inst address until accept; data granted only afterwards.
- MAX_OUTSTANDING=2: three back-to-back inst reads with no responses -> first two accepted, third held with o_inst_addr_ok=0; one i_mem_data_ok -> third accepted on the following cycle.
- Response with cnt == 0, then i_rst pulsed with 2 transactions outstanding -> no data_ok pulses; after reset, cnt == 0 and a new request is accepted normally.
- With YSYX_22050710_SRAM_ARB_RR_EN, both masters requesting continuously, 1-cycle accepts -> grants alternate data, inst, data, inst.
